// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : Memory-stage load/store unit. Sits between the EX/MEM and MEM/WB
//            pipeline registers, issues one access at a time on a registered
//            request/ready data bus, stalls the pipeline while the access is
//            outstanding and returns a sign/zero-extended load result.
// Ports    : clk, reset        - pipeline clock, async active-high reset
//            ALUResultM        - effective byte address
//            WriteDataM        - store data (rs2)
//            funct3M           - RV32I load/store width code
//            MemReadM/WriteM   - instruction in MEM is a load / store
//            ReadDataM         - extended load result (registered)
//            StallM            - hold front of pipe, bubble into MEM/WB
//            MisalignM         - misaligned / illegal access, no bus op
//            FaultM            - bus timeout pulse (DONE cycle)
//            mem_*             - data-memory bus (req/we/addr/wdata/wstrb
//                                out, ready/rdata in)
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        FaultM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]    c_IDLE     = 2'd0;
    localparam logic [1:0]    c_BUSY     = 2'd1;
    localparam logic [1:0]    c_DONE     = 2'd2;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_off;
    logic [2:0]    r_f3;
    logic          r_is_load;
    logic [31:0]   r_rdata;
    logic          r_req;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_fault;

    logic          w_access;
    logic          w_f3_ok;
    logic          w_aligned;
    logic          w_legal;
    logic          w_timeout;
    logic [3:0]    w_strb;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_val;

    // ------------------------------------------------------------------
    // Legality and alignment of the instruction currently in MEM
    // ------------------------------------------------------------------
    assign w_access = MemReadM | MemWriteM;

    always_comb begin
        w_f3_ok = 1'b0;
        if (MemReadM && MemWriteM) begin
            w_f3_ok = 1'b0;
        end else if (MemReadM) begin
            case (funct3M)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end else if (MemWriteM) begin
            case (funct3M)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end
    end

    // Halfword codes share funct3[1:0]=01; word is 010.
    assign w_aligned = !((funct3M[1:0] == 2'b01) && ALUResultM[0]) &&
                       !((funct3M == 3'b010) && (ALUResultM[1:0] != 2'b00));
    assign w_legal   = w_access && w_f3_ok && w_aligned;

    // ------------------------------------------------------------------
    // Store lane replication and byte strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << ALUResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_strb  = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_strb  = 4'b1111;
                w_wdata = WriteDataM;
            end
        endcase
        if (!MemWriteM) begin
            w_strb = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Load extraction from the returned word, using the offset and width
    // latched when the request was issued
    // ------------------------------------------------------------------
    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_f3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_val = {24'd0, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_val = {16'd0, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    assign w_timeout = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_legal) w_next_state = c_BUSY;
            c_BUSY:  if (mem_ready || w_timeout) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: combinational outputs. Gated by reset so the pipeline is
    // released the moment reset is asserted, even mid-access.
    // ------------------------------------------------------------------
    always_comb begin
        StallM    = 1'b0;
        MisalignM = 1'b0;
        if (!reset) begin
            case (r_state)
                c_IDLE: begin
                    StallM    = w_legal;
                    MisalignM = w_access && !w_legal;
                end
                c_BUSY:  StallM = 1'b1;
                default: StallM = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_off     <= 2'b00;
            r_f3      <= 3'b000;
            r_is_load <= 1'b0;
            r_rdata   <= 32'd0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'b0000;
            r_fault   <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_legal) begin
                        r_req     <= 1'b1;
                        r_we      <= MemWriteM;
                        r_addr    <= {ALUResultM[31:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_wstrb   <= w_strb;
                        r_off     <= ALUResultM[1:0];
                        r_f3      <= funct3M;
                        r_is_load <= MemReadM;
                        r_cnt     <= '0;
                    end
                end
                c_BUSY: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    // Ready takes priority over a coincident timeout.
                    if (mem_ready) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_wstrb <= 4'b0000;
                        if (r_is_load) begin
                            r_rdata <= w_load_val;
                        end
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_wstrb <= 4'b0000;
                        r_fault <= 1'b1;
                        if (r_is_load) begin
                            r_rdata <= 32'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ReadDataM = r_rdata;
    assign FaultM    = r_fault;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Purpose  : Self-checking bench for mem_stage_lsu (TIMEOUT=4). Expected load
//            results and fault flags are queued when an access is driven and
//            popped when the unit reaches its DONE cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        FaultM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rd;

    mem_stage_lsu #(.TIMEOUT(TO), .CW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .FaultM     (FaultM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference load extraction written from the RV32I definitions.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] bsh;
        logic [31:0] hsh;
        bsh = w >> (8 * off);
        hsh = off[1] ? (w >> 16) : w;
        case (f3)
            3'b000:  return 32'($signed(bsh[7:0]));
            3'b100:  return {24'd0, bsh[7:0]};
            3'b001:  return 32'($signed(hsh[15:0]));
            3'b101:  return {16'd0, hsh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'b010) return 4'b1111;
        if (f3 == 3'b001) return a[1] ? 4'b1100 : 4'b0011;
        case (a)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'b010) return d;
        if (f3 == 3'b001) return {d[15:0], d[15:0]};
        return {d[7:0], d[7:0], d[7:0], d[7:0]};
    endfunction

    task automatic clear_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        mem_ready  = 1'b0;
    endtask

    // Drive one access (may be called in the DONE cycle of the previous one,
    // which is the back-to-back case) and follow it to its DONE cycle.
    // rdy_at: BUSY cycle index at which mem_ready is given, -1 = never.
    task automatic run_mem(input string name, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] f3, input logic rd, input logic wr,
                           input int rdy_at, input logic [31:0] rdata);
        exp_t e;
        exp_t got_e;
        int   n;
        int   exp_n;
        logic idle_stall;
        logic got;
        logic done;
        ALUResultM = addr;
        WriteDataM = wd;
        funct3M    = f3;
        MemReadM   = rd;
        MemWriteM  = wr;
        mem_ready  = 1'b0;
        e.fault = (rdy_at < 0) || (rdy_at >= TO);
        e.rd    = rd ? (e.fault ? 32'd0 : ref_load(f3, addr[1:0], rdata)) : model_rd;
        model_rd = e.rd;
        sb.push_back(e);
        exp_n = e.fault ? TO : rdy_at + 1;
        #1;
        idle_stall = StallM;
        got = 1'b0;
        for (int c = 0; c < 3 && !got; c++) begin
            @(negedge clk); #1;
            if (mem_req) got = 1'b1;
            else idle_stall = StallM;
        end
        tests++;
        if (got !== 1'b1) begin
            fails++;
            $display("FAIL %s req_issue: mem_req never rose", name);
            void'(sb.pop_back());
            clear_inputs();
            return;
        end
        tests++;
        if (idle_stall !== 1'b1) begin
            fails++;
            $display("FAIL %s idle_stall: got %b expected 1", name, idle_stall);
        end
        n = 0;
        done = 1'b0;
        for (int c = 0; c < TO + 4 && !done; c++) begin
            if (mem_req) begin
                if (n == 0) begin
                    tests++;
                    if (mem_addr !== {addr[31:2], 2'b00}) begin
                        fails++;
                        $display("FAIL %s mem_addr: got %h expected %h", name, mem_addr, {addr[31:2], 2'b00});
                    end
                    tests++;
                    if (mem_we !== wr) begin
                        fails++;
                        $display("FAIL %s mem_we: got %b expected %b", name, mem_we, wr);
                    end
                    tests++;
                    if (mem_wstrb !== (wr ? ref_strb(f3, addr[1:0]) : 4'b0000)) begin
                        fails++;
                        $display("FAIL %s mem_wstrb: got %b expected %b", name, mem_wstrb,
                                 wr ? ref_strb(f3, addr[1:0]) : 4'b0000);
                    end
                    if (wr) begin
                        tests++;
                        if (mem_wdata !== ref_wdata(f3, wd)) begin
                            fails++;
                            $display("FAIL %s mem_wdata: got %h expected %h", name, mem_wdata, ref_wdata(f3, wd));
                        end
                    end
                end
                tests++;
                if (StallM !== 1'b1) begin
                    fails++;
                    $display("FAIL %s busy_stall: got %b expected 1 (busy cycle %0d)", name, StallM, n);
                end
                mem_ready = (n == rdy_at);
                mem_rdata = (n == rdy_at) ? rdata : 32'h5A5A_5A5A;
                n++;
                @(negedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        mem_ready = 1'b0;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s req_drop: mem_req still high after %0d cycles", name, n);
        end
        got_e = sb.pop_front();
        tests++;
        if (n != exp_n) begin
            fails++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_n);
        end
        tests++;
        if (StallM !== 1'b0) begin
            fails++;
            $display("FAIL %s done_stall: got %b expected 0", name, StallM);
        end
        tests++;
        if (FaultM !== got_e.fault) begin
            fails++;
            $display("FAIL %s FaultM: got %b expected %b", name, FaultM, got_e.fault);
        end
        tests++;
        if (ReadDataM !== got_e.rd) begin
            fails++;
            $display("FAIL %s ReadDataM: got %h expected %h", name, ReadDataM, got_e.rd);
        end
        clear_inputs();
    endtask

    // Drive an access that must be rejected, one cycle in IDLE.
    task automatic run_bad(input string name, input logic [31:0] addr, input logic [2:0] f3,
                           input logic rd, input logic wr);
        @(negedge clk); #1;
        ALUResultM = addr;
        WriteDataM = 32'hFFFF_FFFF;
        funct3M    = f3;
        MemReadM   = rd;
        MemWriteM  = wr;
        #1;
        tests++;
        if (MisalignM !== 1'b1) begin
            fails++;
            $display("FAIL %s MisalignM: got %b expected 1", name, MisalignM);
        end
        tests++;
        if (StallM !== 1'b0) begin
            fails++;
            $display("FAIL %s StallM: got %b expected 0", name, StallM);
        end
        @(negedge clk); #1;
        clear_inputs();
        #1;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL %s no_req: got %b expected 0", name, mem_req);
        end
        tests++;
        if (MisalignM !== 1'b0) begin
            fails++;
            $display("FAIL %s misalign_pulse: got %b expected 0", name, MisalignM);
        end
        tests++;
        if (ReadDataM !== model_rd) begin
            fails++;
            $display("FAIL %s ReadDataM: got %h expected %h", name, ReadDataM, model_rd);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        funct3M    = 3'b000;
        mem_rdata  = 32'd0;
        clear_inputs();
        model_rd   = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({mem_req, mem_we, mem_wstrb, StallM, MisalignM, FaultM} !== 9'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0", {mem_req, mem_we, mem_wstrb, StallM, MisalignM, FaultM});
        end
        tests++;
        if ({ReadDataM, mem_addr, mem_wdata} !== 96'd0) begin
            fails++;
            $display("FAIL reset_data: got %h %h %h expected zeros", ReadDataM, mem_addr, mem_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        @(negedge clk); #1;
        run_mem("lw_basic", 32'h100, 32'd0, 3'b010, 1'b1, 1'b0, 0, 32'hDEAD_BEEF);
    endtask

    task automatic test_loads();
        @(negedge clk); #1;
        run_mem("lb",  32'h203, 32'd0, 3'b000, 1'b1, 1'b0, 0, 32'h80FF_1234);
        run_mem("lbu", 32'h203, 32'd0, 3'b100, 1'b1, 1'b0, 1, 32'h80FF_1234);
        run_mem("lhu", 32'h202, 32'd0, 3'b101, 1'b1, 1'b0, 0, 32'h80FF_1234);
        run_mem("lh",  32'h202, 32'd0, 3'b001, 1'b1, 1'b0, 2, 32'h80FF_1234);
        run_mem("lb0", 32'h200, 32'd0, 3'b000, 1'b1, 1'b0, 0, 32'h80FF_1234);
    endtask

    task automatic test_store();
        @(negedge clk); #1;
        run_mem("sb", 32'h7,  32'h0000_00A5, 3'b000, 1'b0, 1'b1, 0, 32'h0);
        run_mem("sh", 32'h6,  32'h1234_ABCD, 3'b001, 1'b0, 1'b1, 1, 32'h0);
        run_mem("sw", 32'h10, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 0, 32'h0);
    endtask

    task automatic test_misalign();
        run_bad("lw_misalign",   32'h102, 3'b010, 1'b1, 1'b0);
        run_bad("ld_illegal",    32'h100, 3'b011, 1'b1, 1'b0);
        run_bad("sh_misalign",   32'h001, 3'b001, 1'b0, 1'b1);
        run_bad("st_illegal_f3", 32'h100, 3'b100, 1'b0, 1'b1);
        run_bad("rd_and_wr",     32'h100, 3'b010, 1'b1, 1'b1);
    endtask

    task automatic test_timeout();
        @(negedge clk); #1;
        run_mem("lw_timeout", 32'h300, 32'd0, 3'b010, 1'b1, 1'b0, -1, 32'h0);
        @(negedge clk); #1;
        tests++;
        if (FaultM !== 1'b0) begin
            fails++;
            $display("FAIL fault_pulse: got %b expected 0", FaultM);
        end
        run_mem("lw_ready_last", 32'h304, 32'd0, 3'b010, 1'b1, 1'b0, TO - 1, 32'h1357_9BDF);
        run_mem("sw_timeout",    32'h308, 32'h11, 3'b010, 1'b0, 1'b1, -1, 32'h0);
    endtask

    task automatic test_ready_ignored();
        @(negedge clk); #1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({mem_req, StallM} !== 2'b00 || ReadDataM !== model_rd) begin
            fails++;
            $display("FAIL ready_ignored: got req=%b stall=%b rd=%h expected 0 0 %h",
                     mem_req, StallM, ReadDataM, model_rd);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk); #1;
        run_mem("b2b_sw",  32'h500, 32'h8765_4321, 3'b010, 1'b0, 1'b1, 0, 32'h0);
        run_mem("b2b_lbu", 32'h501, 32'd0,         3'b100, 1'b1, 1'b0, 0, 32'h8765_4321);
        run_mem("b2b_lh",  32'h502, 32'd0,         3'b001, 1'b1, 1'b0, 0, 32'h8765_4321);
    endtask

    task automatic test_reset_busy();
        logic got;
        @(negedge clk); #1;
        ALUResultM = 32'h400;
        funct3M    = 3'b010;
        MemReadM   = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 3 && !got; c++) begin
            @(negedge clk); #1;
            if (mem_req) got = 1'b1;
        end
        tests++;
        if (got !== 1'b1) begin
            fails++;
            $display("FAIL rst_busy_issue: mem_req never rose");
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({mem_req, StallM} !== 2'b00 || ReadDataM !== 32'd0) begin
            fails++;
            $display("FAIL rst_busy_async: got req=%b stall=%b rd=%h expected 0 0 0",
                     mem_req, StallM, ReadDataM);
        end
        clear_inputs();
        model_rd = 32'd0;
        @(negedge clk); #1;
        reset = 1'b0;
        run_mem("lw_after_rst", 32'h404, 32'd0, 3'b010, 1'b1, 1'b0, 1, 32'h1234_5678);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_loads();
        test_store();
        test_misalign();
        test_timeout();
        test_ready_ignored();
        test_back_to_back();
        test_reset_busy();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs.
- Drives a registered request/ready data-memory bus. Produces sign/zero-extended ReadDataM for writeback.
- Stalls the pipeline while an access is outstanding, and flags misaligned/illegal accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, max cycles in BUSY waiting for mem_ready before an access fault (≥2)
- CW, 5, width of timeout counter (2^CW > TIMEOUT)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store data (rs2)
- funct3M  in  3  RV32I load/store width code
- MemReadM  in  1  instruction in MEM is a load
- MemWriteM  in  1  instruction in MEM is a store
- ReadDataM  out  32  extended load result (registered)
- StallM  out  1  hold IF/ID/EX/MEM; insert bubble into MEM/WB
- MisalignM  out  1  one-cycle pulse: misaligned or illegal-funct3 access, no bus op issued
- FaultM  out  1  one-cycle pulse: bus timeout
- mem_req  out  1  bus request (registered)
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {ALUResultM[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_ready  in  1  bus completion; rdata valid same cycle
- mem_rdata  in  32  read word

Behaviour:
- Reset (async, active-high): state IDLE; ReadDataM, mem_addr, mem_wdata = 0; mem_req, mem_we, mem_wstrb = 0; MisalignM, FaultM = 0; counter = 0. An in-flight access is abandoned immediately.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No MemReadM/MemWriteM: StallM=0, no bus activity.
  - Legal, aligned access: StallM=1 (combinational). At the clock edge, register mem_req=1, mem_we=MemWriteM, address/data/strobes; go to BUSY with counter cleared.
  - MemReadM and MemWriteM both high: treated as illegal.
- Alignment/legality:
  - Half (001/101) requires addr[0]=0; word (010) requires addr[1:0]=0.
  - Legal load funct3 ∈ {000,001,010,100,101}; legal store funct3 ∈ {000,001,010}.
  - Violation: no request, StallM=0, MisalignM=1 for that cycle, ReadDataM unchanged, no write.
- Store strobes:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{WriteDataM[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{WriteDataM[15:0]}}.
  - SW: wstrb = 1111. Loads: wstrb = 0000.
- BUSY:
  - StallM=1; bus outputs held stable; counter increments each cycle.
  - mem_ready=1: capture mem_rdata into ReadDataM (loads only), deassert mem_req at that edge, go to DONE.
  - counter reaches TIMEOUT-1 without ready: deassert mem_req, ReadDataM=0 for loads, FaultM=1 during the DONE cycle, go to DONE.
  - ready in the same cycle as timeout: ready wins, no fault.
- Load extraction: byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: full word.
  - Byte offset and funct3 are latched at request time.
- DONE: StallM=0 for one cycle so the pipeline advances and MEM/WB captures ReadDataM. Next state IDLE.
- Latency: a memory op with ready on the first BUSY cycle occupies MEM for 3 cycles (2 stalled + DONE).
- mem_ready outside BUSY is ignored.
- ReadDataM holds its last value until the next successful load or reset. Stores never modify it.
- Back-to-back memory instructions: the second one is evaluated in IDLE the cycle after DONE.

Test Plan:
- LW at 0x100, mem_ready on 1st BUSY cycle, rdata=0xDEADBEEF -> mem_addr=0x100, wstrb=0000; StallM high 2 cycles; ReadDataM=0xDEADBEEF in DONE.
- LB addr 0x203 rdata=0x80FF1234 -> ReadDataM=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 -> 0x000080FF.
- SB addr 0x7, WriteDataM=0x000000A5 -> mem_addr=0x4, wstrb=1000, wdata=0xA5A5A5A5, mem_we=1; ReadDataM unchanged.
- LW addr 0x102 -> no mem_req, MisalignM pulses 1 cycle, StallM=0; repeat with funct3=011 -> same.
- TIMEOUT=4, ready never asserted -> mem_req drops after 4 BUSY cycles, FaultM=1 one cycle, ReadDataM=0; ready on the 4th cycle instead -> no fault.
- Assert reset during BUSY -> mem_req=0, StallM=0, state IDLE, ReadDataM=0 immediately without a clock edge; a subsequent LW completes normally.
